// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply controller slice.
package matmul_pkg;

    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Row-major element address: row*n + col, truncated to the memory address width.
    function automatic logic [ADDR_W-1:0] row_major(input int unsigned row,
                                                    input int unsigned col,
                                                    input int unsigned n);
        return ADDR_W'(row * n + col);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate: acc <= acc + a*b (unsigned), with synchronous clear.
module mac_unit #(
    parameter int SIZE  = 8,
    parameter int ACC_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [SIZE-1:0]  a,
    input  logic [SIZE-1:0]  b,
    output logic [ACC_W-1:0] acc
);

    logic [2*SIZE-1:0] product;

    assign product = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};

    // Clear wins over enable so a new element always starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + {{(ACC_W-2*SIZE){1'b0}}, product};
        end
    end

endmodule

// File: rtl/matmul_controller.sv
// Sequences C = A x B over single-port memories: one FETCH/MAC pair per k, one WRITE per C element.
module matmul_controller
    import matmul_pkg::*;
#(
    parameter int N     = 2,
    parameter int SIZE  = 8,
    parameter int ACC_W = 2*SIZE + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              a_read,
    output logic [ADDR_W-1:0] a_read_address,
    input  logic [SIZE-1:0]   a_data,
    output logic              b_read,
    output logic [ADDR_W-1:0] b_read_address,
    input  logic [SIZE-1:0]   b_data,
    output logic              c_write,
    output logic [ADDR_W-1:0] c_write_address,
    output logic [ACC_W-1:0]  c_write_value
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  i;
    logic [IDX_W-1:0]  j;
    logic [IDX_W-1:0]  k;
    logic [ACC_W-1:0]  acc;
    logic              mac_clear;
    logic              mac_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? FETCH : IDLE;
            FETCH:   next_state = MAC;
            MAC:     next_state = (k == LAST) ? WRITE : FETCH;
            WRITE:   next_state = ((i == LAST) && (j == LAST)) ? DONE : FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // k walks the inner product; j then i advance once per written element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                MAC: begin
                    if (k != LAST) begin
                        k <= k + 1'b1;
                    end
                end
                WRITE: begin
                    k <= '0;
                    if (j != LAST) begin
                        j <= j + 1'b1;
                    end else begin
                        j <= '0;
                        i <= i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mac_clear = ((state == IDLE) && start) || (state == WRITE);
    assign mac_en    = (state == MAC);

    mac_unit #(
        .SIZE  (SIZE),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .enable (mac_en),
        .a      (a_data),
        .b      (b_data),
        .acc    (acc)
    );

    // Outputs decode the registered state; addresses stay stable across FETCH and MAC.
    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        a_read          = 1'b0;
        b_read          = 1'b0;
        c_write         = 1'b0;
        a_read_address  = '0;
        b_read_address  = '0;
        c_write_address = '0;
        c_write_value   = '0;
        case (state)
            FETCH: begin
                busy           = 1'b1;
                a_read         = 1'b1;
                b_read         = 1'b1;
                a_read_address = row_major(32'(i), 32'(k), N);
                b_read_address = row_major(32'(k), 32'(j), N);
            end
            MAC: begin
                busy           = 1'b1;
                a_read_address = row_major(32'(i), 32'(k), N);
                b_read_address = row_major(32'(k), 32'(j), N);
            end
            WRITE: begin
                busy            = 1'b1;
                c_write         = 1'b1;
                c_write_address = row_major(32'(i), 32'(j), N);
                c_write_value   = acc;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
